// File: rtl/pc_update_sequencer_if.sv
// PC-update request/response bundle between the control unit and the sequencer.
// master: control unit side (drives request), slave: pc_update_sequencer.
interface pc_update_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_type;
    logic       branch_taken;
    logic       exc_opcode;
    logic       exc_ovf;
    logic       exc_div0;
    logic [2:0] pc_source;
    logic       pc_write;
    logic       epc_write;
    logic       mem_read;
    logic [7:0] vec_addr;
    logic [1:0] cause;
    logic       done;

    modport master (
        output req_valid, req_type, branch_taken,
        output exc_opcode, exc_ovf, exc_div0,
        input  req_ready, pc_source, pc_write, epc_write,
        input  mem_read, vec_addr, cause, done
    );

    modport slave (
        input  req_valid, req_type, branch_taken,
        input  exc_opcode, exc_ovf, exc_div0,
        output req_ready, pc_source, pc_write, epc_write,
        output mem_read, vec_addr, cause, done
    );
endinterface

// File: rtl/pc_update_sequencer.sv
// PC-update sequencer: single-cycle PC writes or the EPC/vector-load exception
// sequence. Ports: clk, reset (async active-low), bus (pc_update_sequencer_if.slave).
// Optional PCSEQ_RTE_EN: RTE loads PC from EPC; otherwise RTE is an invalid opcode.
module pc_update_sequencer #(
    parameter int unsigned MEM_LAT    = 2,
    parameter logic [7:0]  VEC_OPCODE = 8'd253,
    parameter logic [7:0]  VEC_OVF    = 8'd254,
    parameter logic [7:0]  VEC_DIV0   = 8'd255
) (
    input logic                  clk,
    input logic                  reset,
    pc_update_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        UPD,
        EXC_EPC,
        EXC_WAIT,
        EXC_LOAD
    } state_e;

    localparam logic [2:0] SRC_JADDR  = 3'd0;
    localparam logic [2:0] SRC_ALU    = 3'd1;
    localparam logic [2:0] SRC_ALUOUT = 3'd2;
    localparam logic [2:0] SRC_MEM    = 3'd3;
    localparam logic [2:0] SRC_EPC    = 3'd4;

    localparam logic [2:0] T_SEQ    = 3'd0;
    localparam logic [2:0] T_BRANCH = 3'd1;
    localparam logic [2:0] T_JUMP   = 3'd2;
    localparam logic [2:0] T_JR     = 3'd3;
    localparam logic [2:0] T_RTE    = 3'd4;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_OPC  = 2'd1;
    localparam logic [1:0] C_OVF  = 2'd2;
    localparam logic [1:0] C_DIV0 = 2'd3;

    // Wait state runs CNT_INIT..0 inclusive, i.e. MEM_LAT cycles.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

`ifdef PCSEQ_RTE_EN
    localparam bit RTE_EN = 1'b1;
`else
    localparam bit RTE_EN = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;
    logic [7:0] vec_q, vec_d;
    logic [2:0] src_q, src_d;
    logic       wr_q, wr_d;

    logic       bad_type;
    logic [1:0] exc_cause;
    logic [7:0] exc_vec;
    logic [2:0] upd_src;

    // RTE without EPC support is treated like any undecodable type.
    assign bad_type = (bus.req_type > T_RTE) ||
                      ((bus.req_type == T_RTE) && !RTE_EN);

    always_comb begin
        exc_cause = C_NONE;
        exc_vec   = 8'd0;
        if (bus.exc_opcode || bad_type) begin
            exc_cause = C_OPC;
            exc_vec   = VEC_OPCODE;
        end else if (bus.exc_div0) begin
            exc_cause = C_DIV0;
            exc_vec   = VEC_DIV0;
        end else if (bus.exc_ovf) begin
            exc_cause = C_OVF;
            exc_vec   = VEC_OVF;
        end
    end

    always_comb begin
        upd_src = SRC_ALU;
        unique case (bus.req_type)
            T_SEQ:    upd_src = SRC_ALU;
            T_BRANCH: upd_src = SRC_ALUOUT;
            T_JUMP:   upd_src = SRC_JADDR;
            T_JR:     upd_src = SRC_ALU;
            T_RTE:    upd_src = SRC_EPC;
            default:  upd_src = SRC_ALU;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        vec_d   = vec_q;
        src_d   = src_q;
        wr_d    = wr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (exc_cause != C_NONE) begin
                        state_d = EXC_EPC;
                        cause_d = exc_cause;
                        vec_d   = exc_vec;
                    end else begin
                        state_d = UPD;
                        src_d   = upd_src;
                        wr_d    = !((bus.req_type == T_BRANCH) &&
                                    !bus.branch_taken);
                    end
                end
            end
            UPD: begin
                state_d = IDLE;
            end
            EXC_EPC: begin
                state_d = EXC_WAIT;
                cnt_d   = CNT_INIT;
            end
            EXC_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = EXC_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            EXC_LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cause_q <= C_NONE;
            vec_q   <= 8'd0;
            src_q   <= SRC_JADDR;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            vec_q   <= vec_d;
            src_q   <= src_d;
            wr_q    <= wr_d;
        end
    end

    // Enables decode from the state register only, so an async reset
    // drops them at once.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.pc_write  = ((state_q == UPD) && wr_q) ||
                           (state_q == EXC_LOAD);
    assign bus.epc_write = (state_q == EXC_EPC);
    assign bus.mem_read  = (state_q == EXC_EPC) ||
                           (state_q == EXC_WAIT);
    assign bus.done      = (state_q == UPD) ||
                           (state_q == EXC_LOAD);
    assign bus.pc_source = (state_q == EXC_LOAD) ? SRC_MEM :
                           (state_q == UPD)      ? src_q   :
                                                   SRC_JADDR;
    assign bus.vec_addr  = vec_q;
    assign bus.cause     = cause_q;

endmodule
